// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the single write port of the 2R/1W register file. After reset, or when
// init_req is seen in RUN, it sweeps zero into every entry (INIT, busy=1).
// In RUN it shares the port among NUM_REQ requesters by round robin.
//
// Optional build macro: RF_ARB_PRIO_EN
//   defined   : requester 0 has fixed top priority; 1..NUM_REQ-1 round robin
//   undefined : pure round robin over all requesters
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   init_req    level; starts a clear sweep when sampled high in RUN
//   req         per-requester write request
//   req_addr    flattened addresses, requester i at [i*adder_width +: adder_width]
//   req_data    flattened data, requester i at [i*data_width +: data_width]
//   gnt         one-hot accept, combinational, RUN only
//   busy        high while sweeping (INIT)
//   rf_we, rf_w_adder, rf_w_data  registered register-file write port
module regfile_write_arbiter #(
  parameter int unsigned data_width  = 8,
  parameter int unsigned adder_width = 3,
  parameter int unsigned NUM_REQ     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_req,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*adder_width-1:0] req_addr,
  input  logic [NUM_REQ*data_width-1:0]  req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           busy,
  output logic                           rf_we,
  output logic [adder_width-1:0]         rf_w_adder,
  output logic [data_width-1:0]          rf_w_data
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [adder_width-1:0] CntMax = '1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_REQ - 1);
`ifdef RF_ARB_PRIO_EN
  // Round-robin pointer only spans requesters 1..NUM_REQ-1.
  localparam logic [PtrW-1:0] PtrRst = PtrW'(1);
`else
  localparam logic [PtrW-1:0] PtrRst = '0;
`endif

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                 state_q;
  logic [adder_width-1:0] cnt_q;
  logic [PtrW-1:0]        ptr_q;
  logic [PtrW-1:0]        ptr_next;
  logic                   gnt_valid;
  logic [PtrW-1:0]        gnt_idx;

  // Grant search. Loops run from the farthest candidate down so the nearest
  // requester at or after ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (state_q == StRun && !init_req) begin
`ifdef RF_ARB_PRIO_EN
      if (req[0]) begin
        gnt_valid = 1'b1;
        gnt_idx   = '0;
      end else begin
        for (int k = int'(NUM_REQ) - 2; k >= 0; k--) begin
          idx = 1 + (int'(ptr_q) - 1 + k) % (int'(NUM_REQ) - 1);
          if (req[idx[PtrW-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx[PtrW-1:0];
          end
        end
      end
`else
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
        idx = (int'(ptr_q) + k) % int'(NUM_REQ);
        if (req[idx[PtrW-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx[PtrW-1:0];
        end
      end
`endif
    end
  end

  always_comb begin
`ifdef RF_ARB_PRIO_EN
    if (gnt_idx == '0) begin
      ptr_next = ptr_q;
    end else if (gnt_idx == PtrLast) begin
      ptr_next = PtrW'(1);
    end else begin
      ptr_next = gnt_idx + PtrW'(1);
    end
`else
    ptr_next = (gnt_idx == PtrLast) ? '0 : gnt_idx + PtrW'(1);
`endif
  end

  assign gnt  = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign busy = (state_q == StInit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      ptr_q      <= PtrRst;
      rf_we      <= 1'b0;
      rf_w_adder <= '0;
      rf_w_data  <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          rf_we      <= 1'b1;
          rf_w_adder <= cnt_q;
          rf_w_data  <= '0;
          if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (init_req) begin
            // Sweep wins over any pending request this cycle.
            state_q <= StInit;
            rf_we   <= 1'b0;
          end else if (gnt_valid) begin
            rf_we      <= 1'b1;
            rf_w_adder <= req_addr[gnt_idx*adder_width +: adder_width];
            rf_w_data  <= req_data[gnt_idx*data_width +: data_width];
            ptr_q      <= ptr_next;
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int N   = 4;
  localparam int DEP = 1 << AW;
  localparam int AWT = N * AW;
  localparam int DWT = N * DW;

  logic           clk;
  logic           rst_n;
  logic           init_req;
  logic [N-1:0]   req;
  logic [AWT-1:0] req_addr;
  logic [DWT-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           rf_we;
  logic [AW-1:0]  rf_w_adder;
  logic [DW-1:0]  rf_w_data;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_arbiter #(
    .data_width (DW),
    .adder_width(AW),
    .NUM_REQ    (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_w_adder(rf_w_adder),
    .rf_w_data (rf_w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file driven by the DUT write port, for read-back checks.
  logic [DW-1:0] tb_rf [DEP];
  always @(posedge clk) if (rf_we) tb_rf[rf_w_adder] <= rf_w_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sweep tracked as "writes left"; grants chosen by distance from ptr.
  int m_busy, m_left, m_ptr, m_we, m_addr, m_data, m_gi;

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef RF_ARB_PRIO_EN
    if (r[0]) return 0;
    for (int d = 0; d < N - 1; d++) begin
      int i = 1 + (p - 1 + d) % (N - 1);
      if (r[i]) return i;
    end
`else
    for (int d = 0; d < N; d++) begin
      int i = (p + d) % N;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1; m_left = DEP; m_we = 0; m_addr = 0; m_data = 0;
`ifdef RF_ARB_PRIO_EN
    m_ptr = 1;
`else
    m_ptr = 0;
`endif
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_we", 32'(rf_we), 0);
      check("rst_addr", 32'(rf_w_adder), 0);
      check("rst_data", 32'(rf_w_data), 0);
    end else begin
      m_gi = (m_busy == 0 && !init_req) ? pick(req, m_ptr) : -1;
      check("m_gnt", 32'(gnt), (m_gi < 0) ? 0 : (1 << m_gi));
      check("m_busy", 32'(busy), m_busy);
      check("m_we", 32'(rf_we), m_we);
      check("m_addr", 32'(rf_w_adder), m_addr);
      check("m_data", 32'(rf_w_data), m_data);
      if (m_busy != 0) begin
        m_we = 1; m_addr = DEP - m_left; m_data = 0; m_left--;
        if (m_left == 0) m_busy = 0;
      end else if (init_req) begin
        m_busy = 1; m_left = DEP; m_we = 0;
      end else if (m_gi >= 0) begin
        m_we   = 1;
        m_addr = int'(req_addr[m_gi*AW +: AW]);
        m_data = int'(req_data[m_gi*DW +: DW]);
`ifdef RF_ARB_PRIO_EN
        if (m_gi != 0) m_ptr = (m_gi == N - 1) ? 1 : m_gi + 1;
`else
        m_ptr = (m_gi + 1) % N;
`endif
      end else begin
        m_we = 0;
      end
    end
  end

  // ---------------- directed checks with literal expectations ----------------
  // Call just after reset release: 8 zero writes, addresses 0..7, then idle.
  task automatic sweep_check();
    @(negedge clk);
    check("sw_pre_busy", 32'(busy), 1);
    check("sw_pre_we", 32'(rf_we), 0);
    for (int k = 0; k < DEP; k++) begin
      @(negedge clk);
      check("sw_we", 32'(rf_we), 1);
      check("sw_addr", 32'(rf_w_adder), k);
      check("sw_data", 32'(rf_w_data), 0);
      check("sw_busy", 32'(busy), (k < DEP - 1) ? 1 : 0);
      check("sw_gnt", 32'(gnt), 0);
    end
    @(negedge clk);
    check("sw_end_we", 32'(rf_we), 0);
    check("sw_end_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    logic [3:0] seq [5];
    rst_n = 1'b0; init_req = 1'b0; req = '0; req_addr = '0; req_data = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    sweep_check();

    // Single requester: grant same cycle, write next cycle.
    @(posedge clk); #1;
    req = 4'b0010;
    req_addr[1*AW +: AW] = 3'd5;
    req_data[1*DW +: DW] = 8'hA5;
    @(negedge clk);
    check("t2_gnt", 32'(gnt), 32'b0010);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("t2_we", 32'(rf_we), 1);
    check("t2_addr", 32'(rf_w_adder), 5);
    check("t2_data", 32'(rf_w_data), 32'hA5);
    @(posedge clk); #1;
    check("t2_read5", 32'(tb_rf[5]), 32'hA5);

`ifndef RF_ARB_PRIO_EN
    // Grant requester 3 to bring ptr back to 0, then all four requesting.
    req = 4'b1000;
    @(posedge clk); #1 req = 4'b1111;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    seq[4] = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t3_gnt", 32'(gnt), 32'(seq[j]));
      if (j > 0) check("t3_we", 32'(rf_we), 1);
      @(posedge clk); #1;
    end
    req = '0;
`else
    req = 4'b1001;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("prio_gnt", 32'(gnt), 32'b0001);
      @(posedge clk); #1;
    end
    req = '0;
`endif

    // init_req beats a pending request; request served after the sweep.
    @(posedge clk); #1;
    req = 4'b0100; init_req = 1'b1;
    @(negedge clk);
    check("t4_gnt0", 32'(gnt), 0);
    @(posedge clk); #1 init_req = 1'b0;
    for (int k = 0; k < DEP; k++) begin
      @(negedge clk);
      check("t4_busy", 32'(busy), 1);
      check("t4_gnt", 32'(gnt), 0);
    end
    @(negedge clk);
    check("t4_busy_end", 32'(busy), 0);
    check("t4_gnt_end", 32'(gnt), 32'b0100);
    @(posedge clk); #1 req = '0;

    // Asynchronous reset while the sweep writes address 3.
    @(posedge clk); #1 init_req = 1'b1;
    @(posedge clk); #1 init_req = 1'b0;
    found = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (rf_we && rf_w_adder == 3'd3 && busy) begin
        found = 1;
        break;
      end
    end
    check("t5_wait_addr3", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_we", 32'(rf_we), 0);
    check("t5_async_busy", 32'(busy), 1);
    check("t5_async_addr", 32'(rf_w_adder), 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    sweep_check();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      req      = N'($urandom_range(0, (1 << N) - 1));
      req_addr = AWT'($urandom());
      req_data = DWT'($urandom());
      init_req = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1 req = '0; init_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
